pipelined_addsub: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor; the N-bit successor to the 8-bit combinational adder/subtractor.
- Operand width is split into STAGES equal slices. One slice resolves per pipeline stage, and the carry is registered between stages.
- Valid/ready handshakes on input and output; produces S plus carry, signed-overflow, zero and negative flags.
- Sits between an operand source (register file / sequencer) and a result sink that may stall.

---
 rtl/addsub_pkg.sv | 22 ++
 rtl/addsub_slice.sv | 23 ++
 rtl/pipelined_addsub.sv | 159 +++++++++++++++
 tb/tb_pipelined_addsub.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
// Latency: n/a (constants, types and an elaboration-time helper only).
// Backpressure: n/a.
package addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Result flags that travel alongside the sum out of the last stage.
   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic negative;
   } flags_t;

   // A legal configuration splits the operands into equal, non-empty slices.
   function automatic bit slice_width_ok(input int width, input int stages);
      return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/addsub_slice.sv
// One W-bit slice of the ripple adder: sum, carry out, and carry into the slice MSB.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline decides when results are captured.
module addsub_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o,
   output logic         cmsb_o
);

   logic [W:0] full;

   assign full   = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
   assign sum_o  = full[W-1:0];
   assign cout_o = full[W];
   // The carry into the MSB is recovered from the MSB sum bit, so no W == 1 special case is needed.
   assign cmsb_o = a_i[W-1] ^ b_i[W-1] ^ full[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub, one WIDTH/STAGES slice per stage; optional saturation via PIPELINED_ADDSUB_SAT_EN.
// Latency: STAGES cycles from accept to out_valid; one beat per cycle sustained.
// Backpressure: whole pipe freezes while out_valid && !out_ready; in_ready = !out_valid || out_ready.
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int W    = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   if (!slice_width_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES");
   end

   logic adv;
   logic sub;

   // Inputs seen by each stage: stage 0 from the ports, stage k from register k-1.
   logic [WIDTH-1:0] st_a [STAGES];
   logic [WIDTH-1:0] st_b [STAGES];
   logic [WIDTH-1:0] st_s [STAGES];
   logic             st_c [STAGES];

   // Per-stage results.
   logic [W-1:0]     sl_sum [STAGES];
   logic [WIDTH-1:0] nxt_s  [STAGES];
   logic             nxt_c  [STAGES];
   logic             cmsb   [STAGES];

   // Inter-stage registers (index k = captured after stage k; the last index is the output).
   logic             vld_q [STAGES];
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] b_q   [STAGES];
   logic [WIDTH-1:0] s_q   [STAGES];
   logic             c_q   [STAGES];

   logic [WIDTH-1:0] res_s_d, res_s_q;
   flags_t           flags_d, flags_q;
   logic             ovf_d;

   assign sub       = (op == OP_SUB);
   assign out_valid = vld_q[LAST];
   assign adv       = !vld_q[LAST] || out_ready;
   assign in_ready  = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         // B is inverted and carry-in set for subtract: A - B = A + ~B + 1.
         assign st_a[k] = a;
         assign st_b[k] = b ^ {WIDTH{sub}};
         assign st_s[k] = '0;
         assign st_c[k] = sub;
      end else begin : g_next
         assign st_a[k] = a_q[k-1];
         assign st_b[k] = b_q[k-1];
         assign st_s[k] = s_q[k-1];
         assign st_c[k] = c_q[k-1];
      end

      addsub_slice #(.W(W)) u_slice (
         .a_i    (st_a[k][k*W +: W]),
         .b_i    (st_b[k][k*W +: W]),
         .cin_i  (st_c[k]),
         .sum_o  (sl_sum[k]),
         .cout_o (nxt_c[k]),
         .cmsb_o (cmsb[k])
      );

      // Upper sum slices are still zero here, so OR-ing drops the new slice into place.
      assign nxt_s[k] = st_s[k] | (WIDTH'(sl_sum[k]) << (k * W));
   end

   assign ovf_d = cmsb[LAST] ^ nxt_c[LAST];

   // Final-stage result: optional saturation, then flags derived from the final sum.
   always_comb begin
      res_s_d          = nxt_s[LAST];
`ifdef PIPELINED_ADDSUB_SAT_EN
      if (ovf_d) begin
         // Overflow direction follows A's sign: a positive A can only overflow upwards.
         res_s_d = st_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
      flags_d.carry    = nxt_c[LAST];
      flags_d.overflow = ovf_d;
      flags_d.zero     = (res_s_d == '0);
      flags_d.negative = res_s_d[WIDTH-1];
   end

   // Valid bits shift together on advance; reset discards every in-flight beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_q[k] <= 1'b0;
         end
      end else if (adv) begin
         vld_q[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) begin
            vld_q[k] <= vld_q[k-1];
         end
      end
   end

   // Intermediate operand/partial-sum/carry registers between stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LAST; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
         end
      end else if (adv) begin
         for (int k = 0; k < LAST; k++) begin
            a_q[k] <= st_a[k];
            b_q[k] <= st_b[k];
            s_q[k] <= nxt_s[k];
            c_q[k] <= nxt_c[k];
         end
      end
   end

   // Output register: held bit-stable whenever the sink stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_s_q <= '0;
         flags_q <= '0;
      end else if (adv) begin
         res_s_q <= res_s_d;
         flags_q <= flags_d;
      end
   end

   assign s        = res_s_q;
   assign carry    = flags_q.carry;
   assign overflow = flags_q.overflow;
   assign zero     = flags_q.zero;
   assign negative = flags_q.negative;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub at WIDTH=8, STAGES=2.
// Directed vector table plus hand-written stream, stall and reset sequences.
// Expected results are hand-computed; saturated variants selected by PIPELINED_ADDSUB_SAT_EN.
module tb_pipelined_addsub;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       op = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] s;
   logic       carry, overflow, zero, negative;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero),
      .negative  (negative)
   );

   // f fields are {carry, overflow, zero, negative}
   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       op;
      logic [7:0] s_w;
      logic [3:0] f_w;
      logic [7:0] s_sat;
      logic [3:0] f_sat;
   } vec_t;

   vec_t vt [12];

   // Stream stimulus with hand-computed expected sums.
   logic [7:0] sa [8];
   logic [7:0] sb [8];
   logic       sop [8];
   logic [7:0] se [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic apply_vec(input int i);
      logic [7:0] es;
      logic [3:0] ef;
`ifdef PIPELINED_ADDSUB_SAT_EN
      es = vt[i].s_sat;
      ef = vt[i].f_sat;
`else
      es = vt[i].s_w;
      ef = vt[i].f_w;
`endif
      @(negedge clk);
      in_valid = 1'b1;
      a = vt[i].a;
      b = vt[i].b;
      op = vt[i].op;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_lat1_valid", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_lat2_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_result", i), {20'd0, s, carry, overflow, zero, negative}, {20'd0, es, ef});
   endtask

   task automatic run_stream(input int n, input int stall_at, input int stall_len, input bit check_rate);
      int bi = 0;
      int ri = 0;
      int cyc = 0;
      int first_d = -1;
      int last_d = -1;
      logic [11:0] held = '0;
      bit hold_ok = 1'b0;
      while (ri < n && cyc < 60) begin
         @(negedge clk);
         in_valid = (bi < n);
         if (bi < n) begin
            a = sa[bi];
            b = sb[bi];
            op = sop[bi];
         end
         out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
         #1;
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (hold_ok) chk("stall_hold", {20'd0, s, carry, overflow, zero, negative}, {20'd0, held});
            held = {s, carry, overflow, zero, negative};
            hold_ok = 1'b1;
         end else begin
            hold_ok = 1'b0;
         end
         if (out_valid && out_ready) begin
            chk($sformatf("stream_beat%0d", ri), 32'(s), 32'(se[ri]));
            if (first_d < 0) first_d = cyc;
            last_d = cyc;
            ri++;
         end
         if (in_valid && in_ready) bi++;
         cyc++;
      end
      if (ri < n) chk("stream_timeout", ri, n);
      if (check_rate) chk("stream_rate", last_d - first_d, n - 1);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         #1;
         chk("stream_no_extra", 32'(out_valid), 32'd0);
      end
   endtask

   initial begin
      vt[0]  = '{8'h01, 8'h80, 1'b0, 8'h81, 4'b0001, 8'h81, 4'b0001};
      vt[1]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 4'b0101, 8'h7F, 4'b0100};
      vt[2]  = '{8'h02, 8'h80, 1'b1, 8'h82, 4'b0101, 8'h7F, 4'b0100};
      vt[3]  = '{8'h05, 8'h05, 1'b1, 8'h00, 4'b1010, 8'h00, 4'b1010};
      vt[4]  = '{8'h80, 8'h80, 1'b1, 8'h00, 4'b1010, 8'h00, 4'b1010};
      vt[5]  = '{8'h00, 8'h80, 1'b1, 8'h80, 4'b0101, 8'h7F, 4'b0100};
      vt[6]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010, 8'h00, 4'b1010};
      vt[7]  = '{8'h80, 8'h80, 1'b0, 8'h00, 4'b1110, 8'h80, 4'b1101};
      vt[8]  = '{8'h3C, 8'h0F, 1'b1, 8'h2D, 4'b1000, 8'h2D, 4'b1000};
      vt[9]  = '{8'h0F, 8'h3C, 1'b1, 8'hD3, 4'b0001, 8'hD3, 4'b0001};
      vt[10] = '{8'hFF, 8'h01, 1'b1, 8'hFE, 4'b1001, 8'hFE, 4'b1001};
      vt[11] = '{8'h10, 8'h20, 1'b0, 8'h30, 4'b0000, 8'h30, 4'b0000};

      // Reset state.
      @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_outputs", {20'd0, s, carry, overflow, zero, negative}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) apply_vec(i);

      // Back-to-back stream: 1+128, 2+127, 3+126, 4+125.
      sa[0] = 8'd1; sb[0] = 8'd128; sop[0] = 1'b0; se[0] = 8'h81;
      sa[1] = 8'd2; sb[1] = 8'd127; sop[1] = 1'b0; se[1] = 8'h81;
      sa[2] = 8'd3; sb[2] = 8'd126; sop[2] = 1'b0; se[2] = 8'h81;
      sa[3] = 8'd4; sb[3] = 8'd125; sop[3] = 1'b0; se[3] = 8'h81;
      run_stream(4, 100, 0, 1'b1);

      // Distinct beats with a 3-cycle sink stall while the pipe is full.
      sa[0] = 8'h11; sb[0] = 8'h01; sop[0] = 1'b0; se[0] = 8'h12;
      sa[1] = 8'h22; sb[1] = 8'h01; sop[1] = 1'b0; se[1] = 8'h23;
      sa[2] = 8'h33; sb[2] = 8'h01; sop[2] = 1'b0; se[2] = 8'h34;
      sa[3] = 8'h44; sb[3] = 8'h01; sop[3] = 1'b1; se[3] = 8'h43;
      sa[4] = 8'h55; sb[4] = 8'h01; sop[4] = 1'b0; se[4] = 8'h56;
      sa[5] = 8'h66; sb[5] = 8'h01; sop[5] = 1'b1; se[5] = 8'h65;
      run_stream(6, 3, 3, 1'b0);

      // Reset with two beats in flight.
      @(negedge clk);
      in_valid = 1'b1; a = 8'h21; b = 8'h03; op = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      a = 8'h42; b = 8'h05;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("prerst_out_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_outputs", {20'd0, s, carry, overflow, zero, negative}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         #1;
         chk("post_rst_no_stale", 32'(out_valid), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
